acc_ctrl_tx_arb: RTL and testbench
==================================

Name: acc_ctrl_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one serial_tx word engine among REQ_NUM command requesters.
- Typical requesters: scan control, laser safety, host register path. Each issues 16-bit ACC class words (e.g. 'h5A50 / 'h5A51) toward the remote acc_ctrl receiver.
- Sequences each word: issue, wait for the engine to start, wait for it to finish, then enforce a minimum inter-word gap.
- Sits between the command sources and serial_tx, on the sending side of the ACC control link.

Parameters:
- DATA_WIDTH, 16, command word width.
- REQ_NUM, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk_i cycles forced after each word before the next grant (0 allowed).
- BUSY_TIMEOUT, 64, cycles allowed for tx_busy_i to rise after tx_valid_o.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  REQ_NUM  per-requester word pending; held until matching ready
- req_data_i  in  REQ_NUM*DATA_WIDTH  requester k word at bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  REQ_NUM  one-hot, 1-cycle pulse; word k accepted
- tx_valid_o  out  1  1-cycle start pulse to serial_tx
- tx_data_o  out  DATA_WIDTH  word to serial; stable from the pulse until back in IDLE
- tx_busy_i  in  1  serial_tx shifting
- grant_id_o  out  $clog2(REQ_NUM)  index of last granted requester
- err_timeout_o  out  1  1-cycle pulse when BUSY_TIMEOUT expires
- sent_cnt_o  out  16  words actually transmitted, saturating at 'hFFFF

Behaviour:
- Reset values (rst_i sampled high on a clk_i edge): all outputs 0, FSM = IDLE, RR pointer = REQ_NUM-1 (so requester 0 has first priority), gap counter 0.
- Reset mid-operation aborts immediately. The word is not retried. No ready pulse is issued for an unaccepted word.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid_i is high and tx_busy_i is low, select the first valid index searching ptr+1, ptr+2, ... modulo REQ_NUM.
  - In the same cycle, latch its word into tx_data_o, register grant_id_o, and update ptr to the winner. Go to ISSUE.
  - If tx_busy_i is high, stay in IDLE. A foreign or residual transfer blocks grants.
- ISSUE (1 cycle):
  - tx_valid_o = 1 and req_ready_o[grant] = 1. Go to WAIT_BUSY.
  - Latency: valid request in IDLE cycle N gives tx_valid_o and ready at N+1.
- WAIT_BUSY:
  - When tx_busy_i = 1, go to WAIT_DONE.
  - Counter counts cycles in this state. If it reaches BUSY_TIMEOUT, pulse err_timeout_o, do not increment sent_cnt_o, and go to GAP.
  - tx_busy_i already high in the first WAIT_BUSY cycle is accepted.
- WAIT_DONE:
  - On tx_busy_i = 0, increment sent_cnt_o (saturating) and go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES = 0 means GAP lasts 0 extra cycles (direct to IDLE on the exit condition).
- Fairness:
  - With all requesters held valid, grants rotate 0,1,2,3,0...
  - A requester that drops valid before grant is skipped without penalty.
  - Requests arriving during non-IDLE states wait. Simultaneous requests resolve by RR order only.
- req_ready_o is never asserted outside ISSUE (except in the filter case below). The word is taken from req_data_i in the IDLE grant cycle.

Optional Feature:
- Macro ACC_TX_DUP_FILTER_EN.
- Defined:
  - The block keeps last_word and a last_vld flag. last_vld is cleared on reset and set on each completed send (WAIT_DONE exit).
  - If the granted word equals last_word and last_vld = 1:
    - pulse req_ready_o[grant] in the cycle after grant;
    - no tx_valid_o, no sent_cnt_o change;
    - return to IDLE without GAP.
  - Timed-out words do not update last_word.
- Not defined: every accepted word is transmitted. No last_word storage.

Test Plan:
- Single send: reset, req 0 sends 'h5A51; tx_busy_i high 2 cycles after the pulse for 16 cycles. Expect tx_valid_o at the cycle after valid, tx_data_o = 'h5A51, req_ready_o = 4'b0001, sent_cnt_o = 1, next grant no earlier than GAP_CYCLES = 16 cycles after busy falls.
- Round-robin: all 4 requesters held valid with words 'h5A50..'h5A53. Expect grant_id_o sequence 0,1,2,3,0 and ready pulses in the same order, one per transfer.
- Busy blocking: tx_busy_i held high before any request; req 2 valid. Expect no grant until tx_busy_i falls, then grant 2 the next cycle.
- Timeout: req 1 valid, tx_busy_i never rises. Expect err_timeout_o pulse 64 cycles after the WAIT_BUSY entry, sent_cnt_o unchanged, FSM passes through GAP and grants again.
- Reset mid-word: assert rst_i during WAIT_DONE. Expect all outputs 0 the next cycle, ptr reset (requester 0 first), no ready for pending requesters.
- Dup filter (macro defined): send 'h5A51 twice from req 3. Expect second ready pulse with no tx_valid_o and sent_cnt_o = 1. Then 'h5A50 is sent normally, sent_cnt_o = 2.

Source files
------------

// File: rtl/acc_ctrl_tx_arb.sv
// ============================================================================
// acc_ctrl_tx_arb
// ----------------------------------------------------------------------------
// Round-robin arbiter and word sequencer that shares one serial_tx word engine
// among REQ_NUM command requesters (scan control, laser safety, host register
// path, ...). Each granted word is issued to serial_tx with a one-cycle start
// pulse. The block waits for the engine to start shifting and then to finish.
// After that it holds off the next grant for GAP_CYCLES idle cycles.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   req_valid_i    per-requester "word pending", held until matching ready
//   req_data_i     requester k word at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o    one-hot, one-cycle pulse: word k accepted
//   tx_valid_o     one-cycle start pulse to serial_tx
//   tx_data_o      word to serial_tx, stable from the pulse until back in IDLE
//   tx_busy_i      serial_tx is shifting
//   grant_id_o     index of the last granted requester
//   err_timeout_o  one-cycle pulse when tx_busy_i failed to rise in time
//   sent_cnt_o     words actually transmitted, saturating at 'hFFFF
//
// Handshake: a requester raises req_valid_i with its word on req_data_i and
// holds both until it sees req_ready_o[k] high for one cycle. The word is
// captured in the grant cycle, one cycle before that ready pulse. On the
// engine side tx_valid_o is a start pulse, not a valid/ready pair. Progress is
// tracked only through tx_busy_i rising and then falling.
//
// Optional build macro: ACC_TX_DUP_FILTER_EN
//   When defined, a granted word equal to the last successfully transmitted
//   word is acknowledged with a ready pulse but not sent. No tx_valid_o pulse
//   is issued, sent_cnt_o is unchanged, and the FSM returns to IDLE without a
//   gap. When undefined, every accepted word is transmitted.
// ============================================================================
module acc_ctrl_tx_arb #(
    parameter int DATA_WIDTH   = 16,
    parameter int REQ_NUM      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_busy_i,
    output logic [$clog2(REQ_NUM)-1:0]    grant_id_o,
    output logic                          err_timeout_o,
    output logic [15:0]                   sent_cnt_o
);

    localparam int PW = $clog2(REQ_NUM);
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Last counter values before the exit condition fires.
    localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [PW:0]   REQ_NUM_W = (PW+1)'(REQ_NUM);
    localparam logic [PW-1:0] PTR_RST   = PW'(REQ_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                  state_q;
    logic [PW-1:0]           ptr_q;
    logic [TW-1:0]           busy_cnt_q;
    logic [GW-1:0]           gap_cnt_q;
    logic [REQ_NUM-1:0]      req_ready_q;
    logic                    tx_valid_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic [PW-1:0]           grant_id_q;
    logic                    err_timeout_q;
    logic [15:0]             sent_cnt_q;

`ifdef ACC_TX_DUP_FILTER_EN
    logic [DATA_WIDTH-1:0]   last_word_q;
    logic                    last_vld_q;
    logic                    dup_q;
    logic                    dup_d;
`endif

    // ------------------------------------------------------------------------
    // Requester word view
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] req_word [REQ_NUM];

    for (genvar k = 0; k < REQ_NUM; k++) begin : g_word
        assign req_word[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Round-robin search: first valid index at ptr+1, ptr+2, ... mod REQ_NUM.
    // Index ptr itself is visited last, so the last winner has lowest priority.
    // ------------------------------------------------------------------------
    logic                  grant_found_d;
    logic [PW-1:0]         grant_d;
    logic [DATA_WIDTH-1:0] grant_data_d;
    logic [PW:0]           cand_sum;
    logic [PW-1:0]         cand;

    always_comb begin
        grant_found_d = 1'b0;
        grant_d       = '0;
        cand_sum      = '0;
        cand          = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            cand_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand_sum >= REQ_NUM_W) begin
                cand_sum = cand_sum - REQ_NUM_W;
            end
            cand = cand_sum[PW-1:0];
            if (!grant_found_d && req_valid_i[cand]) begin
                grant_found_d = 1'b1;
                grant_d       = cand;
            end
        end
        grant_data_d = req_word[grant_d];
    end

`ifdef ACC_TX_DUP_FILTER_EN
    assign dup_d = last_vld_q && (last_word_q == grant_data_d);
`endif

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RST;
            busy_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            req_ready_q   <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            err_timeout_q <= 1'b0;
            sent_cnt_q    <= '0;
`ifdef ACC_TX_DUP_FILTER_EN
            last_word_q   <= '0;
            last_vld_q    <= 1'b0;
            dup_q         <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            req_ready_q   <= '0;
            tx_valid_q    <= 1'b0;
            err_timeout_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Any busy engine, including a transfer started by
                    // someone else, blocks new grants.
                    if (grant_found_d && !tx_busy_i) begin
                        tx_data_q            <= grant_data_d;
                        grant_id_q           <= grant_d;
                        ptr_q                <= grant_d;
                        req_ready_q[grant_d] <= 1'b1;
`ifdef ACC_TX_DUP_FILTER_EN
                        tx_valid_q           <= !dup_d;
                        dup_q                <= dup_d;
`else
                        tx_valid_q           <= 1'b1;
`endif
                        state_q              <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    busy_cnt_q <= '0;
`ifdef ACC_TX_DUP_FILTER_EN
                    // A filtered duplicate is acknowledged only and skips the gap.
                    if (dup_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_BUSY;
                    end
`else
                    state_q    <= ST_WAIT_BUSY;
`endif
                end

                ST_WAIT_BUSY: begin
                    // Busy seen on any cycle here, including the first,
                    // counts as the engine having started.
                    if (tx_busy_i) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (busy_cnt_q == TO_LAST) begin
                        err_timeout_q <= 1'b1;
                        gap_cnt_q     <= '0;
                        state_q       <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + TW'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (sent_cnt_q != 16'hFFFF) begin
                            sent_cnt_q <= sent_cnt_q + 16'd1;
                        end
`ifdef ACC_TX_DUP_FILTER_EN
                        last_word_q <= tx_data_q;
                        last_vld_q  <= 1'b1;
`endif
                        gap_cnt_q   <= '0;
                        state_q     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready_o   = req_ready_q;
    assign tx_valid_o    = tx_valid_q;
    assign tx_data_o     = tx_data_q;
    assign grant_id_o    = grant_id_q;
    assign err_timeout_o = err_timeout_q;
    assign sent_cnt_o    = sent_cnt_q;

endmodule

// File: tb/tb_acc_ctrl_tx_arb.sv
// ============================================================================
// tb_acc_ctrl_tx_arb
// ----------------------------------------------------------------------------
// Directed bench for acc_ctrl_tx_arb. Stimulus pushes the expected ready/valid
// word for each grant into exp_q. A monitor pops and compares whenever the DUT
// pulses tx_valid_o or any req_ready_o bit. A simple serial_tx model raises
// busy 2 cycles after each start pulse and holds it for 16 cycles.
// ============================================================================
`timescale 1ns/1ps
module tb_acc_ctrl_tx_arb;

    localparam int DW  = 16;
    localparam int RN  = 4;
    localparam int EW  = 2 + RN + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- DUT ----------------
    logic [RN-1:0]    req_valid_i = '0;
    logic [RN*DW-1:0] req_data_i  = '0;
    logic [RN-1:0]    req_ready_o;
    logic             tx_valid_o;
    logic [DW-1:0]    tx_data_o;
    logic             tx_busy_i;
    logic [1:0]       grant_id_o;
    logic             err_timeout_o;
    logic [15:0]      sent_cnt_o;

    logic eng_busy   = 1'b0;
    logic force_busy = 1'b0;
    logic eng_en     = 1'b1;
    assign tx_busy_i = eng_busy | force_busy;

    acc_ctrl_tx_arb #(
        .DATA_WIDTH  (16),
        .REQ_NUM     (4),
        .GAP_CYCLES  (16),
        .BUSY_TIMEOUT(64)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_busy_i    (tx_busy_i),
        .grant_id_o   (grant_id_o),
        .err_timeout_o(err_timeout_o),
        .sent_cnt_o   (sent_cnt_o)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    int rq_left [RN] = '{default: 0};
    int last_tx_cyc = -1;
    int fall_cyc    = -1;
    int err_cyc     = -1;
    int err_cnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic post(input int k, input logic [DW-1:0] w, input int n);
        req_data_i[k*DW +: DW] = w;
        rq_left[k]             = n;
        req_valid_i[k]         = 1'b1;
    endtask

    // Expected entry: {grant_id, ready one-hot, tx_valid, tx_data}
    task automatic expect_grant(input int k, input logic [DW-1:0] w, input logic v);
        logic [RN-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        exp_q.push_back({2'(k), r, v, w});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_sent(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(sent_cnt_o) != target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(sent_cnt_o), 32'(target));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
        check({tag, "_ready"},    32'(req_ready_o), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data_o), 32'd0);
        check({tag, "_grant"},    32'(grant_id_o), 32'd0);
        check({tag, "_err"},      32'(err_timeout_o), 32'd0);
        check({tag, "_sent"},     32'(sent_cnt_o), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if (err_timeout_o) begin
            err_cyc = cyc;
            err_cnt = err_cnt + 1;
        end
        if (tx_valid_o) last_tx_cyc = cyc;
        if (tx_valid_o || req_ready_o != '0) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL sb_unexpected: got ready=%b valid=%b data=%h expected no output",
                         req_ready_o, tx_valid_o, tx_data_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", 32'({grant_id_o, req_ready_o, tx_valid_o, tx_data_o}), 32'(e));
            end
        end
    end

    // ---------------- requester model: drop valid after last ready ----------------
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < RN; k++) begin
            if (req_ready_o[k] && rq_left[k] > 0) begin
                rq_left[k] = rq_left[k] - 1;
                if (rq_left[k] == 0) req_valid_i[k] = 1'b0;
            end
        end
    end

    // ---------------- serial_tx model ----------------
    initial forever begin
        @(negedge clk);
        if (tx_valid_o && eng_en) begin
            repeat (2) @(negedge clk);
            eng_busy = 1'b1;
            repeat (16) @(negedge clk);
            eng_busy = 1'b0;
            fall_cyc = cyc;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int t0;
        int r;
        int n;

        rst_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Single send from req 0, then a queued word from req 1 during busy.
        t0 = cyc;
        expect_grant(0, 16'h5A51, 1'b1);
        post(0, 16'h5A51, 1);
        wait_drain(10, "t1_drain");
        check("t1_latency", 32'(last_tx_cyc), 32'(t0 + 1));
        n = 0;
        while (!eng_busy && n < 10) begin
            tick();
            n++;
        end
        expect_grant(1, 16'h5A52, 1'b1);
        post(1, 16'h5A52, 1);
        wait_sent(1, 40, "t1_sent");
        wait_drain(60, "t1b_drain");
        // busy falls mid-cycle F; GAP runs F+1..F+16, IDLE F+17, pulse F+18.
        check("t1_gap", 32'(last_tx_cyc - fall_cyc), 32'd18);
        wait_sent(2, 40, "t1b_sent");

        // Round-robin with all four requesters held valid.
        repeat (20) tick();
        do_reset();
        expect_grant(0, 16'h5A50, 1'b1);
        expect_grant(1, 16'h5A51, 1'b1);
        expect_grant(2, 16'h5A52, 1'b1);
        expect_grant(3, 16'h5A53, 1'b1);
        expect_grant(0, 16'h5A50, 1'b1);
        post(0, 16'h5A50, 2);
        post(1, 16'h5A51, 1);
        post(2, 16'h5A52, 1);
        post(3, 16'h5A53, 1);
        wait_drain(400, "rr_drain");
        wait_sent(5, 60, "rr_sent");

        // Busy blocking: foreign busy holds off req 2 until it falls.
        repeat (20) tick();
        force_busy = 1'b1;
        expect_grant(2, 16'h5A62, 1'b1);
        post(2, 16'h5A62, 1);
        repeat (10) tick();
        check("blk_no_grant", 32'(exp_q.size()), 32'd1);
        r = cyc;
        force_busy = 1'b0;
        wait_drain(5, "blk_drain");
        check("blk_latency", 32'(last_tx_cyc), 32'(r + 1));
        wait_sent(6, 60, "blk_sent");

        // Timeout: engine never starts.
        repeat (20) tick();
        eng_en = 1'b0;
        expect_grant(1, 16'h5A61, 1'b1);
        post(1, 16'h5A61, 1);
        wait_drain(5, "to_drain");
        t0 = last_tx_cyc;
        n = 0;
        while (err_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        check("to_err_cnt", 32'(err_cnt), 32'd1);
        check("to_err_time", 32'(err_cyc), 32'(t0 + 65));
        check("to_sent", 32'(sent_cnt_o), 32'd6);
        eng_en = 1'b1;
        expect_grant(3, 16'h5A63, 1'b1);
        post(3, 16'h5A63, 1);
        wait_drain(30, "to_regrant_drain");
        // GAP occupies err_cyc..err_cyc+15, IDLE at +16, pulse at +17.
        check("to_regrant_time", 32'(last_tx_cyc), 32'(err_cyc + 17));
        wait_sent(7, 60, "to_regrant_sent");

        // Reset during WAIT_DONE with req 0 and req 2 pending.
        repeat (20) tick();
        expect_grant(0, 16'h1234, 1'b1);
        post(0, 16'h1234, 1);
        wait_drain(5, "rm_drain");
        repeat (6) tick();
        post(0, 16'h0A00, 1);
        post(2, 16'h0A02, 1);
        rst_i = 1'b1;
        tick();
        check_all_zero("rm");
        rst_i = 1'b0;
        // Pointer back at REQ_NUM-1: requester 0 wins over requester 2.
        expect_grant(0, 16'h0A00, 1'b1);
        expect_grant(2, 16'h0A02, 1'b1);
        wait_drain(200, "rm_drain2");
        wait_sent(2, 60, "rm_sent");

`ifdef ACC_TX_DUP_FILTER_EN
        // Duplicate filter: second identical word is acknowledged, not sent.
        repeat (20) tick();
        do_reset();
        expect_grant(3, 16'h5A51, 1'b1);
        post(3, 16'h5A51, 1);
        wait_drain(10, "dup_first_drain");
        wait_sent(1, 60, "dup_first_sent");
        repeat (20) tick();
        expect_grant(3, 16'h5A51, 1'b0);
        post(3, 16'h5A51, 1);
        wait_drain(10, "dup_second_drain");
        repeat (5) tick();
        check("dup_sent_hold", 32'(sent_cnt_o), 32'd1);
        expect_grant(3, 16'h5A50, 1'b1);
        post(3, 16'h5A50, 1);
        wait_drain(20, "dup_third_drain");
        wait_sent(2, 60, "dup_third_sent");
`endif

        repeat (5) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
